// File: rtl/mmio_console_tx.sv
// mmio_console_tx: memory-mapped serial console transmitter.
// TXDATA (write) sits at BASE_ADDR, STATUS (read; write clears OVF) at BASE_ADDR+4.
// Bytes queue in a small FIFO and leave on TxD as 8N1 frames, LSB first.
// Optional macro CONSOLE_PARITY_EN inserts an even-parity bit before STOP.
module mmio_console_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0800,
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        TxD,
   output logic        Busy
);

   localparam int unsigned ptrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [31:0] statusAdr  = BASE_ADDR + 32'd4;
   localparam logic [15:0] baudReload = 16'(CLKS_PER_BIT - 1);
   localparam logic [4:0]  fullCount  = 5'(FIFO_DEPTH);

`ifdef CONSOLE_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} txStateT;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} txStateT;
`endif

   txStateT         state, stateNext;
   logic [7:0]      fifoMem [FIFO_DEPTH];
   logic [ptrW-1:0] wrPtr, rdPtr;
   logic [4:0]      count;
   logic            ovf;
   logic [7:0]      shiftReg;
   logic [2:0]      bitCnt;
   logic [15:0]     baudCnt;
`ifdef CONSOLE_PARITY_EN
   logic            parityBit;
`endif

   logic txWrite, statusWrite, push, pop;
   logic full, empty, baudDone, busyFsm;
   logic unusedWriteData;

   assign txWrite     = MemWrite && (DataAdr == BASE_ADDR);
   assign statusWrite = MemWrite && (DataAdr == statusAdr);
   assign full        = (count == fullCount);
   assign empty       = (count == 5'd0);
   // Full is judged before any same-edge pop, so a write into a full FIFO always drops.
   assign push        = txWrite && !full;
   assign pop         = (state == StIdle) && !empty;
   assign baudDone    = (baudCnt == 16'd0);
   assign unusedWriteData = ^WriteData[31:8];

   assign Busy     = busyFsm || !empty;
   assign ReadData = (DataAdr == statusAdr) ? {23'b0, count, ovf, busyFsm, empty, full} : 32'd0;

   // FIFO storage; contents need no reset since pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (push) fifoMem[wrPtr] <= WriteData[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= 5'd0;
         ovf   <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + ptrW'(1);
         if (pop)  rdPtr <= rdPtr + ptrW'(1);
         case ({push, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
         if (txWrite && full) ovf <= 1'b1;
         else if (statusWrite) ovf <= 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= StIdle;
      else        state <= stateNext;
   end

   // FSM next-state: each non-idle state lasts one full baud period.
   always_comb begin
      stateNext = state;
      unique case (state)
         StIdle:  if (!empty) stateNext = StStart;
         StStart: if (baudDone) stateNext = StData;
`ifdef CONSOLE_PARITY_EN
         StData:   if (baudDone && bitCnt == 3'd7) stateNext = StParity;
         StParity: if (baudDone) stateNext = StStop;
`else
         StData:  if (baudDone && bitCnt == 3'd7) stateNext = StStop;
`endif
         StStop:  if (baudDone) stateNext = StIdle;
         default: stateNext = StIdle;
      endcase
   end

   // FSM outputs: line level and the busy flag reported in STATUS.
   always_comb begin
      TxD     = 1'b1;
      busyFsm = 1'b1;
      unique case (state)
         StIdle:   busyFsm = 1'b0;
         StStart:  TxD = 1'b0;
         StData:   TxD = shiftReg[0];
`ifdef CONSOLE_PARITY_EN
         StParity: TxD = parityBit;
`endif
         StStop:   TxD = 1'b1;
         default:  busyFsm = 1'b0;
      endcase
   end

   // Shift register, bit counter and baud down-counter (reloaded on every state entry).
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         shiftReg  <= 8'd0;
         bitCnt    <= 3'd0;
         baudCnt   <= 16'd0;
`ifdef CONSOLE_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else if (pop) begin
         shiftReg  <= fifoMem[rdPtr];
         bitCnt    <= 3'd0;
         baudCnt   <= baudReload;
`ifdef CONSOLE_PARITY_EN
         parityBit <= ^fifoMem[rdPtr];
`endif
      end else if (state != StIdle) begin
         if (baudDone) begin
            baudCnt <= baudReload;
            if (state == StData) begin
               shiftReg <= {1'b0, shiftReg[7:1]};
               bitCnt   <= bitCnt + 3'd1;
            end
         end else begin
            baudCnt <= baudCnt - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mmio_console_tx.sv
// tb_mmio_console_tx: directed bench for mmio_console_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_mmio_console_tx;

   localparam int CPB = 4;
`ifdef CONSOLE_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic        CLK = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        TxD;
   logic        Busy;

   int nChecks = 0;
   int nPass   = 0;

   mmio_console_tx #(
      .BASE_ADDR   (32'h0000_0800),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (8)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .MemWrite (MemWrite),
      .DataAdr  (DataAdr),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .TxD      (TxD),
      .Busy     (Busy)
   );

   always #5 CLK = ~CLK;

   // Expected line level for bit slot idx of a frame carrying byte b.
   function automatic logic frameBit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef CONSOLE_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h804; WriteData = 32'd0;
      #2 reset = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      nChecks++; if (TxD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TxD); else nPass++;
      nChecks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else nPass++;
      nChecks++;
      if (ReadData !== 32'h002) $display("FAIL reset_status: got %h expected 002", ReadData);
      else nPass++;
      @(negedge CLK);
      reset = 1'b1;
   endtask

   // Starts on the same falling edge that released reset: first push is at the very next edge.
   task automatic test_frame();
      MemWrite = 1'b1; DataAdr = 32'h800; WriteData = 32'hDEAD_BE41;
      @(negedge CLK);
      MemWrite = 1'b0; DataAdr = 32'h804;
      #1;
      nChecks++; if (TxD !== 1'b1) $display("FAIL frame_prestart: got %b expected 1", TxD); else nPass++;
      nChecks++;
      if (ReadData !== 32'h010) $display("FAIL frame_status_queued: got %h expected 010", ReadData);
      else nPass++;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge CLK);
         nChecks++;
         if (TxD !== frameBit(8'h41, i / CPB))
            $display("FAIL frame41_bit: cycle %0d got %b expected %b", i, TxD, frameBit(8'h41, i / CPB));
         else nPass++;
      end
      nChecks++; if (Busy !== 1'b1) $display("FAIL frame_busy_stop: got %b expected 1", Busy); else nPass++;
      @(negedge CLK);
      nChecks++; if (TxD !== 1'b1) $display("FAIL frame_end_txd: got %b expected 1", TxD); else nPass++;
      nChecks++; if (Busy !== 1'b0) $display("FAIL frame_end_busy: got %b expected 0", Busy); else nPass++;
   endtask

   task automatic test_back_to_back();
      logic expBit;
      @(negedge CLK);
      MemWrite = 1'b1; DataAdr = 32'h800; WriteData = 32'h55;
      @(negedge CLK);
      WriteData = 32'hAA;
      @(negedge CLK);
      MemWrite = 1'b0;
      for (int j = 0; j < 2 * FRAME + 2; j++) begin
         if (j > 0) @(negedge CLK);
         if (j < FRAME)             expBit = frameBit(8'h55, j / CPB);
         else if (j == FRAME)       expBit = 1'b1;
         else if (j < 2 * FRAME + 1) expBit = frameBit(8'hAA, (j - FRAME - 1) / CPB);
         else                       expBit = 1'b1;
         nChecks++;
         if (TxD !== expBit) $display("FAIL b2b_bit: cycle %0d got %b expected %b", j, TxD, expBit);
         else nPass++;
         if (j == FRAME || j == 2 * FRAME) begin
            nChecks++;
            if (Busy !== 1'b1) $display("FAIL b2b_busy_mid: cycle %0d got %b expected 1", j, Busy);
            else nPass++;
         end
      end
      nChecks++; if (Busy !== 1'b0) $display("FAIL b2b_busy_end: got %b expected 0", Busy); else nPass++;
   endtask

   task automatic test_other_addr();
      int lows = 0;
      @(negedge CLK);
      MemWrite = 1'b1; DataAdr = 32'h808; WriteData = 32'h99;
      @(negedge CLK);
      MemWrite = 1'b0; DataAdr = 32'h800;
      #1;
      nChecks++; if (ReadData !== 32'd0) $display("FAIL read_txdata: got %h expected 0", ReadData); else nPass++;
      DataAdr = 32'h808;
      #1;
      nChecks++; if (ReadData !== 32'd0) $display("FAIL read_808: got %h expected 0", ReadData); else nPass++;
      DataAdr = 32'h804;
      #1;
      nChecks++;
      if (ReadData !== 32'h002) $display("FAIL other_status: got %h expected 002", ReadData);
      else nPass++;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (TxD !== 1'b1 || Busy !== 1'b0) lows++;
      end
      nChecks++; if (lows !== 0) $display("FAIL other_no_tx: got %0d active cycles expected 0", lows); else nPass++;
   endtask

   // 0x80 frames have exactly one falling edge (the start bit) with or without parity.
   task automatic test_overflow();
      logic prevTxd = 1'b1;
      int   falls   = 0;
      int   budget  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (prevTxd && !TxD) falls++;
         prevTxd  = TxD;
         MemWrite = 1'b1; DataAdr = 32'h800; WriteData = 32'h80;
      end
      @(negedge CLK);
      if (prevTxd && !TxD) falls++;
      prevTxd  = TxD;
      MemWrite = 1'b0; DataAdr = 32'h804;
      #1;
      nChecks++; if (ReadData !== 32'h08D) $display("FAIL ovf_status: got %h expected 08d", ReadData); else nPass++;
      MemWrite = 1'b1; WriteData = 32'hFFFF_FFFF;
      @(negedge CLK);
      if (prevTxd && !TxD) falls++;
      prevTxd  = TxD;
      MemWrite = 1'b0;
      #1;
      nChecks++; if (ReadData !== 32'h085) $display("FAIL ovf_clear: got %h expected 085", ReadData); else nPass++;
      while (Busy && budget < 800) begin
         @(negedge CLK);
         if (prevTxd && !TxD) falls++;
         prevTxd = TxD;
         budget++;
      end
      nChecks++; if (Busy !== 1'b0) $display("FAIL ovf_drain_timeout: got %b expected 0", Busy); else nPass++;
      nChecks++; if (falls !== 9) $display("FAIL ovf_frames: got %0d expected 9", falls); else nPass++;
      #1;
      nChecks++;
      if (ReadData !== 32'h002) $display("FAIL ovf_final_status: got %h expected 002", ReadData);
      else nPass++;
   endtask

   // Leaves the first frame (0x30) in flight for test_reset_mid.
   task automatic test_status_mid();
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         MemWrite = 1'b1; DataAdr = 32'h800; WriteData = 32'h30 + i;
      end
      @(negedge CLK);
      MemWrite = 1'b0; DataAdr = 32'h804;
      #1;
      nChecks++; if (ReadData !== 32'h034) $display("FAIL status_mid: got %h expected 034", ReadData); else nPass++;
   endtask

   task automatic test_reset_mid();
      int lows = 0;
      // Currently at frame cycle 2; cycle 17 is inside data bit 3 (0 for 0x30).
      repeat (15) @(negedge CLK);
      nChecks++; if (TxD !== 1'b0) $display("FAIL mid_bit3: got %b expected 0", TxD); else nPass++;
      reset = 1'b0;
      #1;
      nChecks++; if (TxD !== 1'b1) $display("FAIL mid_reset_txd: got %b expected 1", TxD); else nPass++;
      nChecks++; if (Busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", Busy); else nPass++;
      repeat (2) @(negedge CLK);
      reset = 1'b1;
      #1;
      nChecks++;
      if (ReadData !== 32'h002) $display("FAIL mid_reset_status: got %h expected 002", ReadData);
      else nPass++;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (TxD !== 1'b1 || Busy !== 1'b0) lows++;
      end
      nChecks++; if (lows !== 0) $display("FAIL mid_no_frame: got %0d active cycles expected 0", lows); else nPass++;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_other_addr();
      test_overflow();
      test_status_mid();
      test_reset_mid();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/mmio_console_tx.md
MMIO_CONSOLE_TX -- requirements
Module: mmio_console_tx

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0800, giving the word address of TXDATA; STATUS is at BASE_ADDR+4.
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 434, giving the CLK cycles per serial bit (legal range 2..65535).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 8, giving the transmit FIFO entries (power of two, 2..16).
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port MemWrite, input, 1 bit: processor store strobe, sampled each rising edge.
REQ-007 The module SHALL have port DataAdr, input, 32 bits: processor data address.
REQ-008 The module SHALL have port WriteData, input, 32 bits: processor store data.
REQ-009 The module SHALL have port ReadData, output, 32 bits: combinational read data for a STATUS address, else 0.
REQ-010 The module SHALL have port TxD, output, 1 bit: serial line, idle high.
REQ-011 The module SHALL have port Busy, output, 1 bit: high while the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-012 A TXDATA write SHALL push WriteData[7:0] into the FIFO at that edge; WriteData[31:8] is ignored. A TXDATA write is MemWrite=1 with DataAdr==BASE_ADDR.
REQ-013 A TXDATA write while the FIFO is full SHALL be dropped and SHALL set sticky OVF; this holds even if a pop occurs on the same edge.
REQ-014 A STATUS write SHALL clear OVF; WriteData is ignored; any other address SHALL be ignored.
REQ-015 ReadData at STATUS SHALL be {23'b0, count[4:0], OVF, busy_fsm, empty, full} with bit0=full, bit1=empty, bit2=busy_fsm, bit3=OVF, bits[8:4]=count.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the shift register and enter START at the same edge.
REQ-018 Latency: a write at edge k into an empty FIFO in IDLE SHALL drive TxD low after edge k+1.
REQ-019 Each of START, each DATA bit, PARITY and STOP SHALL hold TxD for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded on entry.
REQ-020 DATA SHALL send the byte LSB first across 8 bits; START drives 0 and STOP drives 1.
REQ-021 After STOP the FSM SHALL return to IDLE for exactly one cycle (TxD=1) before the next pop, so back-to-back frames are separated by one CLK.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range from 0 to FIFO_DEPTH.
REQ-023 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged and preserve order.

Reset
REQ-024 reset=0 SHALL asynchronously force the FSM to IDLE, TxD=1, count=0, pointers=0, OVF=0, bit counter=0, and baud counter=0; Busy SHALL then read 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately (TxD high within the same cycle) and discard all FIFO contents.
REQ-026 The first push SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-027 With CONSOLE_PARITY_EN defined, the FSM SHALL insert PARITY between DATA and STOP, driving the even parity (XOR of the 8 data bits), for an 11-bit frame.
REQ-028 Without CONSOLE_PARITY_EN, the PARITY state and its logic SHALL be absent, for a 10-bit frame.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-029 Write 0x41 to 0x800 after reset -> TxD low from edge+1, then 1,0,0,0,0,0,1,0 each bit 4 cycles, then stop high; frame length 40 cycles (44 with parity, parity bit=0).
REQ-030 Write 0x55 then 0xAA on consecutive cycles -> two frames in order with exactly one idle-high cycle between them; Busy falls after the second stop bit.
REQ-031 Write 10 bytes in 10 consecutive cycles -> 9 accepted (1 popped plus 8 queued), 10th dropped, STATUS bit3=1; write to 0x804 -> bit3=0.
REQ-032 Read 0x804 with 3 bytes queued and idle FSM blocked mid-frame -> ReadData=0x34 (count=3, busy_fsm=1).
REQ-033 Assert reset during DATA bit 3 -> TxD=1 in the same cycle; after release STATUS=0x002 and no further frame appears.
REQ-034 Write to 0x808 and a read of 0x800 -> no FIFO change and ReadData=0.
